// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the split decimal fixed-point blocks.
// A value is carried as a signed integer part X plus a five-digit decimal fraction Y.
package fixed_point_pkg;

   localparam int FP_SCALE      = 100000;
   localparam int FP_NEG_ZERO_X = 256;
   localparam int FP_X_MAX      = 255;
   localparam int FP_Y_MAX      = 99999;
   localparam int FP_FRAC_BITS  = 17;

   localparam int FP_INT_W = 21;
   localparam int FP_X_W   = 10;
   localparam int FP_Y_W   = 18;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INT,
      S_FRAC,
      S_PACK
   } divState_e;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module restoring_div_step #(
   parameter int W = 38
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] divisor_i,
   input  logic         bit_i,
   output logic [W-1:0] rem_o,
   output logic         qBit_o
);

   logic [W:0] shifted;
   logic [W:0] divisorExt;

   always_comb begin
      shifted    = {rem_i, bit_i};
      divisorExt = {1'b0, divisor_i};
      qBit_o     = (shifted >= divisorExt);
      rem_o      = qBit_o ? W'(shifted - divisorExt) : shifted[W-1:0];
   end

endmodule

// File: rtl/int_div_int_to_fixed_point.sv
// Multi-cycle signed integer divider producing a saturated (fixed_X, fixed_Y) pair.
// Integer quotient bits come first, then 17 decimal-fraction bits, one bit per cycle.
module int_div_int_to_fixed_point
   import fixed_point_pkg::*;
#(
   parameter int INT_W = FP_INT_W,
   parameter int X_W   = FP_X_W,
   parameter int Y_W   = FP_Y_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [INT_W-1:0] num,
   input  logic signed [INT_W-1:0] den,
   output logic                    busy,
   output logic                    done,
   output logic signed [X_W-1:0]   fixed_X,
   output logic        [Y_W-1:0]   fixed_Y,
   output logic                    overflow,
   output logic                    div_by_zero
);

   localparam int DIV_W = INT_W + FP_FRAC_BITS;
   localparam int CNT_W = $clog2(INT_W);
   localparam int FB    = FP_FRAC_BITS;

   divState_e               stateQ, stateD;
   logic [CNT_W-1:0]        cntQ, cntD;
   logic [INT_W-1:0]        dividendQ, dividendD;
   logic [INT_W-1:0]        divisorQ, divisorD;
   logic [DIV_W-1:0]        remQ, remD;
   logic [INT_W-1:0]        quotQ, quotD;
   logic [FB-1:0]           fracBitsQ, fracBitsD;
   logic [FB-1:0]           fracQ, fracD;
   logic                    negQ, negD;
   logic                    numNegQ, numNegD;
   logic                    denZeroQ, denZeroD;
   logic signed [X_W-1:0]   xQ, xD;
   logic [Y_W-1:0]          yQ, yD;
   logic                    ovfQ, ovfD;
   logic                    dbzQ, dbzD;
   logic                    doneQ, doneD;

   logic [INT_W-1:0]        numAbs, denAbs;
   logic [DIV_W-1:0]        stepDivisor, stepRem, scaledRem;
   logic                    stepBit, stepQ;

   // The single step unit serves both phases; only the incoming dividend bit differs.
   assign stepBit     = (stateQ == S_FRAC) ? fracBitsQ[FB-1] : dividendQ[INT_W-1];
   assign stepDivisor = {{FB{1'b0}}, divisorQ};
   assign scaledRem   = stepRem * DIV_W'(FP_SCALE);
   assign numAbs      = num[INT_W-1] ? -num : num;
   assign denAbs      = den[INT_W-1] ? -den : den;

   restoring_div_step #(.W(DIV_W)) uStep (
      .rem_i     (remQ),
      .divisor_i (stepDivisor),
      .bit_i     (stepBit),
      .rem_o     (stepRem),
      .qBit_o    (stepQ)
   );

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      dividendD = dividendQ;
      divisorD  = divisorQ;
      remD      = remQ;
      quotD     = quotQ;
      fracBitsD = fracBitsQ;
      fracD     = fracQ;
      negD      = negQ;
      numNegD   = numNegQ;
      denZeroD  = denZeroQ;
      xD        = xQ;
      yD        = yQ;
      ovfD      = ovfQ;
      dbzD      = dbzQ;
      doneD     = 1'b0;

      unique case (stateQ)
         S_IDLE: begin
            if (start) begin
               stateD    = S_INT;
               cntD      = '0;
               dividendD = numAbs;
               divisorD  = denAbs;
               remD      = '0;
               quotD     = '0;
               negD      = num[INT_W-1] ^ den[INT_W-1];
               numNegD   = num[INT_W-1];
               denZeroD  = (den == '0);
            end
         end

         S_INT: begin
            dividendD = {dividendQ[INT_W-2:0], 1'b0};
            quotD     = {quotQ[INT_W-2:0], stepQ};
            remD      = stepRem;
            cntD      = cntQ + 1'b1;
            // Last integer bit: the quotient of remainder*SCALE fits in FB bits,
            // so its high part seeds the partial remainder and only FB bits remain.
            if (cntQ == CNT_W'(INT_W - 1)) begin
               stateD    = S_FRAC;
               cntD      = '0;
               remD      = scaledRem >> FB;
               fracBitsD = scaledRem[FB-1:0];
               fracD     = '0;
            end
         end

         S_FRAC: begin
            fracBitsD = {fracBitsQ[FB-2:0], 1'b0};
            fracD     = {fracQ[FB-2:0], stepQ};
            remD      = stepRem;
            cntD      = cntQ + 1'b1;
            if (cntQ == CNT_W'(FB - 1)) begin
               stateD = S_PACK;
            end
         end

         S_PACK: begin
            stateD = S_IDLE;
            doneD  = 1'b1;
            ovfD   = 1'b0;
            dbzD   = 1'b0;
            if (denZeroQ) begin
               xD   = numNegQ ? -X_W'(FP_X_MAX) : X_W'(FP_X_MAX);
               yD   = Y_W'(FP_Y_MAX);
               dbzD = 1'b1;
            end else if (quotQ > INT_W'(FP_X_MAX)) begin
               xD   = negQ ? -X_W'(FP_X_MAX) : X_W'(FP_X_MAX);
               yD   = Y_W'(FP_Y_MAX);
               ovfD = 1'b1;
            end else if (quotQ == '0 && fracQ == '0) begin
               xD = '0;
               yD = '0;
            end else if (negQ) begin
               // A negative result below one in magnitude needs the negative-zero marker.
               xD = (quotQ == '0) ? X_W'(FP_NEG_ZERO_X) : -X_W'(quotQ);
               yD = Y_W'(fracQ);
            end else begin
               xD = X_W'(quotQ);
               yD = Y_W'(fracQ);
            end
         end

         default: begin
            stateD = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= S_IDLE;
         cntQ      <= '0;
         dividendQ <= '0;
         divisorQ  <= '0;
         remQ      <= '0;
         quotQ     <= '0;
         fracBitsQ <= '0;
         fracQ     <= '0;
         negQ      <= 1'b0;
         numNegQ   <= 1'b0;
         denZeroQ  <= 1'b0;
         xQ        <= '0;
         yQ        <= '0;
         ovfQ      <= 1'b0;
         dbzQ      <= 1'b0;
         doneQ     <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         dividendQ <= dividendD;
         divisorQ  <= divisorD;
         remQ      <= remD;
         quotQ     <= quotD;
         fracBitsQ <= fracBitsD;
         fracQ     <= fracD;
         negQ      <= negD;
         numNegQ   <= numNegD;
         denZeroQ  <= denZeroD;
         xQ        <= xD;
         yQ        <= yD;
         ovfQ      <= ovfD;
         dbzQ      <= dbzD;
         doneQ     <= doneD;
      end
   end

   assign busy        = (stateQ != S_IDLE);
   assign done        = doneQ;
   assign fixed_X     = xQ;
   assign fixed_Y     = yQ;
   assign overflow    = ovfQ;
   assign div_by_zero = dbzQ;

endmodule

// File: tb/tb_int_div_int_to_fixed_point.sv
// Directed, table-driven bench for the integer-to-fixed-point divider,
// plus hand-written sequences for handshake, back-to-back and reset corners.
module tb_int_div_int_to_fixed_point;

   localparam int INT_W = 21;
   localparam int X_W   = 10;
   localparam int Y_W   = 18;
   localparam int LAT   = 39;
   localparam int NVEC  = 18;

   typedef struct {
      int n;
      int d;
      int expX;
      int expY;
      int expOvf;
      int expDbz;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic signed [INT_W-1:0] num;
   logic signed [INT_W-1:0] den;
   logic                    busy;
   logic                    done;
   logic signed [X_W-1:0]   fixed_X;
   logic        [Y_W-1:0]   fixed_Y;
   logic                    overflow;
   logic                    div_by_zero;

   int compared   = 0;
   int mismatched = 0;
   vec_t vecs [NVEC];

   int_div_int_to_fixed_point #(
      .INT_W (INT_W),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num         (num),
      .den         (den),
      .busy        (busy),
      .done        (done),
      .fixed_X     (fixed_X),
      .fixed_Y     (fixed_Y),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint act, input longint expected);
      compared++;
      if (act != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expected);
      end
   endtask

   // Drives a request for one cycle; returns #1 after the accepting edge.
   task automatic applyStimulus(input int n, input int d);
      num   = INT_W'(n);
      den   = INT_W'(d);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Must be called #1 after the accepting edge; returns in the done cycle.
   task automatic waitResult(output int lat, output int busyCycles);
      lat        = -1;
      busyCycles = busy ? 1 : 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busyCycles++;
      end
   endtask

   task automatic checkResult(input string tag, input int expX, input int expY,
                              input int expOvf, input int expDbz);
      checkOutput({tag, " fixed_X"}, longint'(fixed_X), expX);
      checkOutput({tag, " fixed_Y"}, longint'(fixed_Y), expY);
      checkOutput({tag, " overflow"}, longint'(overflow), expOvf);
      checkOutput({tag, " div_by_zero"}, longint'(div_by_zero), expDbz);
   endtask

   initial begin
      int    lat;
      int    busyCycles;
      int    doneSeen;
      string tag;

      vecs[0]  = '{7, 2, 3, 50000, 0, 0};
      vecs[1]  = '{-7, 2, -3, 50000, 0, 0};
      vecs[2]  = '{-1, 3, 256, 33333, 0, 0};
      vecs[3]  = '{1, -3, 256, 33333, 0, 0};
      vecs[4]  = '{1000, 3, 255, 99999, 1, 0};
      vecs[5]  = '{-1000, 3, -255, 99999, 1, 0};
      vecs[6]  = '{0, 7, 0, 0, 0, 0};
      vecs[7]  = '{0, -7, 0, 0, 0, 0};
      vecs[8]  = '{100, 7, 14, 28571, 0, 0};
      vecs[9]  = '{-100, 7, -14, 28571, 0, 0};
      vecs[10] = '{-1, -3, 0, 33333, 0, 0};
      vecs[11] = '{255, 1, 255, 0, 0, 0};
      vecs[12] = '{256, 1, 255, 99999, 1, 0};
      vecs[13] = '{123456, 1000, 123, 45600, 0, 0};
      vecs[14] = '{-1048576, 1048575, -1, 0, 0, 0};
      vecs[15] = '{1048574, 1048575, 0, 99999, 0, 0};
      vecs[16] = '{5, 0, 255, 99999, 0, 1};
      vecs[17] = '{-5, 0, -255, 99999, 0, 1};

      reset = 1'b1;
      start = 1'b0;
      num   = '0;
      den   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", longint'(busy), 0);
      checkOutput("reset done", longint'(done), 0);
      checkResult("reset", 0, 0, 0, 0);
      reset = 1'b0;

      for (int v = 0; v < NVEC; v++) begin
         tag = $sformatf("vec%0d %0d/%0d", v, vecs[v].n, vecs[v].d);
         applyStimulus(vecs[v].n, vecs[v].d);
         waitResult(lat, busyCycles);
         checkOutput({tag, " latency"}, lat, LAT);
         checkOutput({tag, " busy cycles"}, busyCycles, LAT);
         checkOutput({tag, " busy in done cycle"}, longint'(busy), 0);
         checkResult(tag, vecs[v].expX, vecs[v].expY, vecs[v].expOvf, vecs[v].expDbz);
         @(posedge clk);
         #1;
         checkOutput({tag, " done pulse width"}, longint'(done), 0);
      end

      // Abort 7/2 during its 20th cycle; outputs still hold the -5/0 result.
      applyStimulus(7, 2);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("abort busy", longint'(busy), 0);
      checkOutput("abort done", longint'(done), 0);
      checkResult("abort", 0, 0, 0, 0);
      doneSeen = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (done) doneSeen++;
      end
      checkOutput("abort no done", doneSeen, 0);
      applyStimulus(9, 4);
      waitResult(lat, busyCycles);
      checkOutput("9/4 latency", lat, LAT);
      checkResult("9/4", 2, 25000, 0, 0);
      @(posedge clk);
      #1;

      // 22/7 with start pulses and operand churn while busy.
      applyStimulus(22, 7);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
         start = i[0];
         num   = INT_W'(100 + i);
         den   = INT_W'(3);
      end
      checkOutput("22/7 latency", lat, LAT);
      checkResult("22/7", 3, 14285, 0, 0);

      // Start issued in the done cycle must be accepted immediately.
      applyStimulus(1, 8);
      checkOutput("b2b busy", longint'(busy), 1);
      checkOutput("b2b done low", longint'(done), 0);
      waitResult(lat, busyCycles);
      checkOutput("1/8 latency", lat, LAT);
      checkResult("1/8", 0, 12500, 0, 0);
      @(posedge clk);
      #1;

      // Reset and start on the same edge: reset wins.
      reset = 1'b1;
      num   = INT_W'(7);
      den   = INT_W'(2);
      start = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      checkOutput("reset+start busy", longint'(busy), 0);
      checkResult("reset+start", 0, 0, 0, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("reset+start still idle", longint'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
